// File: rtl/trig_route_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// trig_route_pkg - default widths, invalid-select trigger value, slice helper
// Rev 1.0
// ----------------------------------------------------------------------------
package trig_route_pkg;

  localparam int C_SOURCES         = 4;
  localparam int C_OUTPUTS         = 2;
  localparam int C_SEL_WIDTH       = 2;
  localparam int C_STRETCH_WIDTH   = 8;
  localparam int C_HEARTBEAT_WIDTH = 23;
  localparam int C_COUNT_WIDTH     = 16;

  // Value an output sees when its select points past the last source.
  localparam logic C_INVALID_SEL_TRIG = 1'b0;

  function automatic int sel_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trig_route_chan.sv
`default_nettype none
// ----------------------------------------------------------------------------
// trig_route_chan - one routed output: select/pending, invert, stretch, edge
// counter (built only with TRIG_ROUTE_EDGE_COUNT_EN).   Rev 1.0
// ----------------------------------------------------------------------------
module trig_route_chan
  import trig_route_pkg::*;
#(
  parameter int pSOURCES       = C_SOURCES,
  parameter int pSEL_WIDTH     = C_SEL_WIDTH,
  parameter int pSTRETCH_WIDTH = C_STRETCH_WIDTH,
  parameter int pCOUNT_WIDTH   = C_COUNT_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [pSOURCES-1:0]       i_sources,
  input  logic [pSEL_WIDTH-1:0]     i_sel,
  input  logic                      i_sel_wr,
  input  logic                      i_invert,
  input  logic [pSTRETCH_WIDTH-1:0] i_stretch,
  input  logic                      i_count_clear,
  output logic                      o_trig,
  output logic                      o_sel_pending,
  output logic [pCOUNT_WIDTH-1:0]   o_edge_count
);

  logic [pSEL_WIDTH-1:0]     r_active_sel;
  logic [pSEL_WIDTH-1:0]     r_pending_sel;
  logic                      r_pending;
  logic                      r_s_d;
  logic                      r_trig;
  logic [pSTRETCH_WIDTH-1:0] r_cnt;
  logic [pSTRETCH_WIDTH-1:0] w_cnt_nxt;
  logic                      w_src;
  logic                      w_valid;
  logic                      w_s;
  logic                      w_rise;
  logic                      w_busy;
  logic                      w_apply;

  always_comb begin
    w_src   = 1'b0;
    w_valid = 1'b0;
    for (int k = 0; k < pSOURCES; k++) begin
      if (r_active_sel == pSEL_WIDTH'(k)) begin
        w_src   = i_sources[k];
        w_valid = 1'b1;
      end
    end
  end

  assign w_s     = w_valid ? (w_src ^ i_invert) : C_INVALID_SEL_TRIG;
  assign w_rise  = w_s & ~r_s_d;
  assign w_busy  = (r_cnt != '0);
  // Switching only while fully idle keeps pulses from being cut or merged.
  assign w_apply = r_pending & ~r_trig & ~w_busy;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_rise) begin
      w_cnt_nxt = (i_stretch == '0) ? '0 : i_stretch - pSTRETCH_WIDTH'(1);
    end else if (w_busy) begin
      w_cnt_nxt = r_cnt - pSTRETCH_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active_sel  <= '0;
      r_pending_sel <= '0;
      r_pending     <= 1'b0;
      r_s_d         <= 1'b0;
      r_trig        <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_s_d  <= w_s;
      r_cnt  <= w_cnt_nxt;
      r_trig <= w_s | w_busy;
      if (w_apply) begin
        r_active_sel <= r_pending_sel;
      end
      // A write landing on an apply cycle stays pending for the next idle slot.
      if (i_sel_wr) begin
        r_pending_sel <= i_sel;
        r_pending     <= 1'b1;
      end else if (w_apply) begin
        r_pending     <= 1'b0;
      end
    end
  end

  assign o_trig        = r_trig;
  assign o_sel_pending = r_pending;

`ifdef TRIG_ROUTE_EDGE_COUNT_EN
  logic                    r_trig_d;
  logic [pCOUNT_WIDTH-1:0] r_edge_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trig_d   <= 1'b0;
      r_edge_cnt <= '0;
    end else begin
      r_trig_d <= r_trig;
      if (i_count_clear) begin
        r_edge_cnt <= '0;
      end else if (r_trig & ~r_trig_d & ~(&r_edge_cnt)) begin
        r_edge_cnt <= r_edge_cnt + pCOUNT_WIDTH'(1);
      end
    end
  end

  assign o_edge_count = r_edge_cnt;
`else
  logic w_unused_clear;
  assign w_unused_clear = i_count_clear;
  assign o_edge_count   = '0;
`endif

endmodule
`default_nettype wire

// File: rtl/trig_route.sv
`default_nettype none
// ----------------------------------------------------------------------------
// trig_route - N-source to M-output trigger router with LED heartbeat;
// edge counters built with TRIG_ROUTE_EDGE_COUNT_EN.   Rev 1.0
// ----------------------------------------------------------------------------
module trig_route
  import trig_route_pkg::*;
#(
  parameter int pSOURCES         = C_SOURCES,
  parameter int pOUTPUTS         = C_OUTPUTS,
  parameter int pSEL_WIDTH       = C_SEL_WIDTH,
  parameter int pSTRETCH_WIDTH   = C_STRETCH_WIDTH,
  parameter int pHEARTBEAT_WIDTH = C_HEARTBEAT_WIDTH,
  parameter int pCOUNT_WIDTH     = C_COUNT_WIDTH
) (
  input  logic                             target_clk,
  input  logic                             resetn,
  input  logic [pSOURCES-1:0]              I_sources,
  input  logic [pOUTPUTS*pSEL_WIDTH-1:0]   I_sel,
  input  logic [pOUTPUTS-1:0]              I_sel_wr,
  input  logic [pOUTPUTS-1:0]              I_invert,
  input  logic [pSTRETCH_WIDTH-1:0]        I_stretch,
  input  logic                             I_count_clear,
  output logic [pOUTPUTS-1:0]              O_trig,
  output logic [pOUTPUTS-1:0]              O_sel_pending,
  output logic [pOUTPUTS*pCOUNT_WIDTH-1:0] O_edge_count,
  output logic                             O_heartbeat
);

  logic [pHEARTBEAT_WIDTH-1:0] r_hb_cnt;
  logic                        w_any_trig;

  for (genvar gi = 0; gi < pOUTPUTS; gi++) begin : g_chan
    trig_route_chan #(
      .pSOURCES       (pSOURCES),
      .pSEL_WIDTH     (pSEL_WIDTH),
      .pSTRETCH_WIDTH (pSTRETCH_WIDTH),
      .pCOUNT_WIDTH   (pCOUNT_WIDTH)
    ) u_chan (
      .clk           (target_clk),
      .rst_n         (resetn),
      .i_sources     (I_sources),
      .i_sel         (I_sel[sel_lo(gi, pSEL_WIDTH) +: pSEL_WIDTH]),
      .i_sel_wr      (I_sel_wr[gi]),
      .i_invert      (I_invert[gi]),
      .i_stretch     (I_stretch),
      .i_count_clear (I_count_clear),
      .o_trig        (O_trig[gi]),
      .o_sel_pending (O_sel_pending[gi]),
      .o_edge_count  (O_edge_count[sel_lo(gi, pCOUNT_WIDTH) +: pCOUNT_WIDTH])
    );
  end

  assign w_any_trig = |O_trig;

  // The LED stops blinking while any trigger is active.
  always_ff @(posedge target_clk or negedge resetn) begin
    if (!resetn) begin
      r_hb_cnt <= '0;
    end else if (!w_any_trig) begin
      r_hb_cnt <= r_hb_cnt + pHEARTBEAT_WIDTH'(1);
    end
  end

  assign O_heartbeat = r_hb_cnt[pHEARTBEAT_WIDTH-1];

endmodule
`default_nettype wire

// File: tb/tb_trig_route.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_trig_route - directed and random stimulus against a timeline model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_trig_route;

  localparam int S    = 4;
  localparam int O    = 2;
  localparam int SW   = 3;
  localparam int STW  = 8;
  localparam int HBW  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef TRIG_ROUTE_EDGE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic              target_clk;
  logic              resetn;
  logic [S-1:0]      I_sources;
  logic [O*SW-1:0]   I_sel;
  logic [O-1:0]      I_sel_wr;
  logic [O-1:0]      I_invert;
  logic [STW-1:0]    I_stretch;
  logic              I_count_clear;
  logic [O-1:0]      O_trig;
  logic [O-1:0]      O_sel_pending;
  logic [O*CW-1:0]   O_edge_count;
  logic              O_heartbeat;

  trig_route #(
    .pSOURCES(S), .pOUTPUTS(O), .pSEL_WIDTH(SW), .pSTRETCH_WIDTH(STW),
    .pHEARTBEAT_WIDTH(HBW), .pCOUNT_WIDTH(CW)
  ) dut (
    .target_clk    (target_clk),
    .resetn        (resetn),
    .I_sources     (I_sources),
    .I_sel         (I_sel),
    .I_sel_wr      (I_sel_wr),
    .I_invert      (I_invert),
    .I_stretch     (I_stretch),
    .I_count_clear (I_count_clear),
    .O_trig        (O_trig),
    .O_sel_pending (O_sel_pending),
    .O_edge_count  (O_edge_count),
    .O_heartbeat   (O_heartbeat)
  );

  initial target_clk = 1'b0;
  always #5 target_clk = ~target_clk;

  // Model: each output remembers when its last rise happened and how long
  // the stretch requested at that moment was; high = source or inside window.
  int m_act [O];
  int m_psel[O];
  int m_rise_t[O];
  int m_neff[O];
  int m_cnt [O];
  bit m_pend[O];
  bit m_sprev[O];
  bit m_trig[O];
  bit m_trig_d[O];
  int m_hb;
  int t;
  int n_chk;
  int n_err;
  int hi0;
  bit hb_ref;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, t);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < O; i++) begin
      m_act[i] = 0; m_psel[i] = 0; m_rise_t[i] = -1000; m_neff[i] = 1;
      m_cnt[i] = 0; m_pend[i] = 0; m_sprev[i] = 0; m_trig[i] = 0; m_trig_d[i] = 0;
    end
    m_hb = 0;
  endtask

  task automatic step();
    logic [S-1:0]    src;
    logic [O*SW-1:0] sel;
    logic [O-1:0]    wr, inv;
    int              stretch;
    bit              clr, rst, any, s, busy, apply, rout;
    src = I_sources; sel = I_sel; wr = I_sel_wr; inv = I_invert;
    stretch = int'(I_stretch); clr = I_count_clear; rst = resetn;
    @(posedge target_clk);
    if (!rst) begin
      model_reset();
    end else begin
      any = 0;
      for (int i = 0; i < O; i++) any |= m_trig[i];
      if (!any) m_hb = (m_hb + 1) % (1 << HBW);
      for (int i = 0; i < O; i++) begin
        s     = (m_act[i] < S) ? (src[m_act[i]] ^ inv[i]) : 1'b0;
        busy  = (t - m_rise_t[i]) < m_neff[i];
        apply = m_pend[i] && !m_trig[i] && !busy;
        rout  = m_trig[i] && !m_trig_d[i];
        if (clr) m_cnt[i] = 0;
        else if (rout && m_cnt[i] < CMAX) m_cnt[i]++;
        m_trig_d[i] = m_trig[i];
        m_trig[i]   = s || busy;
        if (s && !m_sprev[i]) begin
          m_rise_t[i] = t;
          m_neff[i]   = (stretch == 0) ? 1 : stretch;
        end
        if (apply) begin m_act[i] = m_psel[i]; m_pend[i] = 0; end
        if (wr[i]) begin m_psel[i] = int'(sel[i*SW +: SW]); m_pend[i] = 1; end
        m_sprev[i] = s;
      end
    end
    t++;
    #1;
    for (int i = 0; i < O; i++) begin
      chk($sformatf("trig%0d", i), int'(O_trig[i]), int'(m_trig[i]));
      chk($sformatf("pend%0d", i), int'(O_sel_pending[i]), int'(m_pend[i]));
      chk($sformatf("ecnt%0d", i), int'(O_edge_count[i*CW +: CW]), CNT_EN ? m_cnt[i] : 0);
    end
    chk("heartbeat", int'(O_heartbeat), (m_hb >> (HBW - 1)) & 1);
    if (O_trig[0]) hi0++;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input int k, input int len);
    I_sources[k] = 1'b1;
    repeat (len) step();
    I_sources[k] = 1'b0;
  endtask

  task automatic wr_sel(input int o, input int v);
    I_sel[o*SW +: SW] = SW'(v);
    I_sel_wr[o] = 1'b1;
    step();
    I_sel_wr[o] = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_err = 0; hi0 = 0; t = 0;
    resetn = 1'b0; I_sources = '0; I_sel = '0; I_sel_wr = '0; I_invert = '0;
    I_stretch = '0; I_count_clear = 1'b0;
    model_reset();
    idle(3);
    chk("rst_trig", int'(O_trig), 0);
    chk("rst_pend", int'(O_sel_pending), 0);
    chk("rst_hb", int'(O_heartbeat), 0);
    chk("rst_ecnt", int'(O_edge_count), 0);
    resetn = 1'b1;
    idle(2);

    // Stretch 0: single-cycle pulse gives one cycle high.
    wr_sel(0, 1); idle(2);
    hi0 = 0; pulse(1, 1); idle(3); chk("w_stretch0", hi0, 1);

    I_stretch = 8'd5;
    hi0 = 0; pulse(1, 1); idle(8); chk("w_stretch5", hi0, 5);
    hi0 = 0; pulse(1, 1); idle(2); pulse(1, 1); idle(10); chk("w_retrig", hi0, 8);
    hi0 = 0; pulse(1, 10); idle(8); chk("w_long", hi0, 10);

    // Select change requested mid-stretch waits for the pulse to finish.
    hi0 = 0; pulse(1, 1); step(); wr_sel(0, 2);
    chk("pend_mid", int'(O_sel_pending[0]), 1);
    idle(8);
    chk("w_sel_mid", hi0, 5);
    chk("pend_done", int'(O_sel_pending[0]), 0);
    hi0 = 0; pulse(2, 1); idle(7); chk("w_src2", hi0, 5);
    hi0 = 0; pulse(1, 1); idle(6); chk("w_old_src", hi0, 0);

    // Out-of-range select holds the output low even when inverted.
    I_stretch = '0;
    wr_sel(0, 5); idle(2);
    I_invert[0] = 1'b1;
    hi0 = 0; idle(5); chk("w_invalid", hi0, 0);
    wr_sel(0, 3); idle(2);
    chk("inv_high", int'(O_trig[0]), 1);
    I_invert[0] = 1'b0; idle(3);

    // Edge counter saturation and clear priority.
    wr_sel(0, 1); idle(2);
    I_count_clear = 1'b1; step(); I_count_clear = 1'b0;
    repeat (20) begin pulse(1, 1); step(); end
    idle(2);
    chk("ecnt_sat", int'(O_edge_count[CW-1:0]), CNT_EN ? 15 : 0);
    I_sources[1] = 1'b1; step(); I_sources[1] = 1'b0;
    I_count_clear = 1'b1; step(); I_count_clear = 1'b0;
    idle(3);
    chk("ecnt_clr", int'(O_edge_count[CW-1:0]), 0);

    // Heartbeat frozen while a trigger is held high.
    I_sources[1] = 1'b1; idle(2);
    hb_ref = O_heartbeat;
    idle(100);
    chk("hb_frozen", int'(O_heartbeat), int'(hb_ref));
    I_sources[1] = 1'b0; idle(3);

    // Asynchronous reset aborts a stretch immediately.
    I_stretch = 8'd20;
    pulse(1, 1); idle(3);
    chk("pre_rst", int'(O_trig[0]), 1);
    #2 resetn = 1'b0;
    #1 chk("rst_async", int'(O_trig[0]), 0);
    idle(2);
    resetn = 1'b1;

    I_stretch = '0;
    repeat (1500) begin
      for (int k = 0; k < S; k++) I_sources[k] = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < O; i++) begin
        I_sel_wr[i] = ($urandom_range(0, 15) == 0);
        I_sel[i*SW +: SW] = SW'($urandom_range(0, 7));
        if ($urandom_range(0, 31) == 0) I_invert[i] = ~I_invert[i];
      end
      if ($urandom_range(0, 31) == 0) I_stretch = STW'($urandom_range(0, 9));
      I_count_clear = ($urandom_range(0, 63) == 0);
      step();
    end
    I_sel_wr = '0; I_count_clear = 1'b0; I_sources = '0;
    idle(12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
